// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_pkg
// Brief   : Shared IEEE-754 single-precision constants and FSM state encoding
// Revision: 1.0
// ============================================================================
package fp_pkg;

    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] PINF     = 32'h7F80_0000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_NORM = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/mant_mul24.sv
`default_nettype none
// ============================================================================
// Module  : mant_mul24
// Brief   : Shift-add mantissa multiplier engine, one partial product per step
// Revision: 1.0
// ============================================================================
module mant_mul24 #(
    parameter int MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [MANT_W-1:0]     i_m,
    output logic [2*MANT_W-1:0]   o_acc,
    output logic                  o_last
);

    localparam int                CNT_W  = $clog2(MANT_W);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(MANT_W - 1);

    logic [MANT_W-1:0]    r_m;
    logic [2*MANT_W-1:0]  r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*MANT_W-1:0]  w_addend;

    assign w_addend = {{MANT_W{1'b0}}, r_m} << r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_m   <= i_m;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            if (r_m[r_cnt])
                r_acc <= r_acc + w_addend;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == C_LAST);

endmodule : mant_mul24
`default_nettype wire

// File: rtl/fp_square.sv
`default_nettype none
// ============================================================================
// Module  : fp_square
// Brief   : Iterative IEEE-754 single-precision squarer (Out = A*A), RNE
// Revision: 1.0
// ============================================================================
module fp_square
    import fp_pkg::*;
#(
    parameter int MANT_W   = 24,
    parameter int EXP_BIAS = fp_pkg::EXP_BIAS
) (
    input  logic        sq_clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] Out
);

    localparam logic signed [9:0] C_BIAS = 10'(EXP_BIAS);

    state_t                r_state;
    logic [7:0]            r_exp;

    logic [7:0]            w_exp_in;
    logic [22:0]           w_frac_in;
    logic                  w_accept;
    logic                  w_is_nan;
    logic                  w_is_inf;
    logic                  w_is_zero;
    logic                  w_load;
    logic [2*MANT_W-1:0]   w_p;
    logic                  w_last;

    logic                  w_n;
    logic [22:0]           w_mant;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_rup;
    logic [23:0]           w_mant_r;
    logic                  w_rcarry;
    logic signed [9:0]     w_e2;
    logic [31:0]           w_norm_out;

    assign w_exp_in  = A[30:23];
    assign w_frac_in = A[22:0];
    assign w_is_nan  = (w_exp_in == EXP_MAX) && (w_frac_in != 23'd0);
    assign w_is_inf  = (w_exp_in == EXP_MAX) && (w_frac_in == 23'd0);
    assign w_is_zero = (w_exp_in == 8'd0);
    assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_load    = w_accept && !w_is_nan && !w_is_inf && !w_is_zero;

    mant_mul24 #(
        .MANT_W (MANT_W)
    ) u_mul (
        .clk    (sq_clk),
        .rst    (reset),
        .i_load (w_load),
        .i_step (r_state == ST_MUL),
        .i_m    ({1'b1, w_frac_in}),
        .o_acc  (w_p),
        .o_last (w_last)
    );

    // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the binade.
    assign w_n      = w_p[47];
    assign w_mant   = w_n ? w_p[46:24] : w_p[45:23];
    assign w_guard  = w_n ? w_p[23]    : w_p[22];
    assign w_sticky = w_n ? (|w_p[22:0]) : (|w_p[21:0]);
    assign w_rup    = w_guard && (w_sticky || w_mant[0]);
    assign w_mant_r = {1'b0, w_mant} + {23'd0, w_rup};
    assign w_rcarry = w_mant_r[23];

    // An all-ones mantissa that rounds up wraps to zero, so only the exponent moves.
    assign w_e2 = $signed({1'b0, r_exp, 1'b0}) - C_BIAS
                + $signed({9'd0, w_n}) + $signed({9'd0, w_rcarry});

    always_comb begin
        w_norm_out = {1'b0, w_e2[7:0], w_mant_r[22:0]};
        if (w_e2 >= 10'sd255)
            w_norm_out = PINF;
        else if (w_e2 <= 10'sd0)
            w_norm_out = 32'h0;
    end

    always_ff @(posedge sq_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_exp   <= 8'd0;
            Out     <= 32'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    if (w_accept) begin
                        r_exp <= w_exp_in;
                        if (w_is_nan) begin
                            Out     <= QNAN;
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else if (w_is_inf) begin
                            Out     <= PINF;
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else if (w_is_zero) begin
                            Out     <= 32'h0;
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_MUL;
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_last)
                        r_state <= ST_NORM;
                end
                ST_NORM: begin
                    Out     <= w_norm_out;
                    r_state <= ST_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : fp_square
`default_nettype wire
